// File: rtl/esm_pkg.sv
// esm_pkg: field positions, table sizes and LFSR constants shared by ESM and esm_unmap
package esm_pkg;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS = 32;
    localparam int RD_LSB = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/esm_lfsr.sv
// esm_lfsr: Fibonacci LFSR, shift left with feedback into bit 0, advanced on step
// ports: clk, rst (sync, loads seed), step (advance once), seed (reset value), state (current value)
module esm_lfsr import esm_pkg::*; #(
    parameter int bs = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic [bs-1:0] seed,
    output logic [bs-1:0] state
);
    localparam logic [bs-1:0] TAPS = bs'(LFSR_TAPS);
    always_ff @(posedge clk) begin
        if (rst) state <= seed;
        else if (step) state <= {state[bs-2:0], ^(state & TAPS)};
    end
endmodule

// File: rtl/esm_unmap.sv
// esm_unmap: restores logical register indices in scrambled instructions, tracking ESM's remapping
// ports: clk, rst (sync active-high), in_valid/Instr_in/RegWrite/ALUSrc (scrambled input),
//        out_valid/Instr_out (restored instruction, one cycle later; held while out_valid=0)
module esm_unmap import esm_pkg::*; #(
    parameter int Instruction_word_size = 32,
    parameter int bs = 16,
    parameter logic [bs-1:0] SEED = bs'(DEFAULT_SEED)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [Instruction_word_size-1:0] Instr_in,
    input  logic                             RegWrite,
    input  logic                             ALUSrc,
    output logic                             out_valid,
    output logic [Instruction_word_size-1:0] Instr_out
);
    reg_idx_t fwd [NUM_REGS];
    reg_idx_t inv [NUM_REGS];
    logic [bs-1:0] lfsr;
    reg_idx_t rd_l, rs1_l, rs2_f, k, fwd_rd, fwd_k;
    logic upd, do_swap;
    logic [Instruction_word_size-1:0] instr_dec;

    esm_lfsr #(.bs(bs)) u_lfsr (
        .clk(clk),
        .rst(rst),
        .step(upd),
        .seed(SEED),
        .state(lfsr)
    );

    always_comb begin
        rd_l = inv[Instr_in[RD_LSB +: REG_IDX_W]];
        rs1_l = inv[Instr_in[RS1_LSB +: REG_IDX_W]];
        rs2_f = ALUSrc ? Instr_in[RS2_LSB +: REG_IDX_W] : inv[Instr_in[RS2_LSB +: REG_IDX_W]];
        instr_dec = Instr_in;
        instr_dec[RD_LSB +: REG_IDX_W] = rd_l;
        instr_dec[RS1_LSB +: REG_IDX_W] = rs1_l;
        instr_dec[RS2_LSB +: REG_IDX_W] = rs2_f;
        k = lfsr[REG_IDX_W-1:0];
        upd = in_valid & RegWrite;
        // logical 0 is never a swap partner, so x0 stays pinned to physical 0
        do_swap = upd && k != '0 && rd_l != '0 && k != rd_l;
        fwd_rd = fwd[rd_l];
        fwd_k = fwd[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                fwd[i] <= reg_idx_t'(i);
                inv[i] <= reg_idx_t'(i);
            end
            out_valid <= 1'b0;
            Instr_out <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) Instr_out <= instr_dec;
            if (do_swap) begin
                fwd[rd_l] <= fwd_k;
                fwd[k] <= fwd_rd;
                inv[fwd_rd] <= k;
                inv[fwd_k] <= rd_l;
            end
        end
    end
endmodule

// File: tb/tb_esm_unmap.sv
// tb_esm_unmap: randomized and directed checks of esm_unmap against a permutation model of ESM
module tb_esm_unmap;
    import esm_pkg::*;
    logic clk = 1'b0;
    logic rst, in_valid, RegWrite, ALUSrc, out_valid;
    logic [31:0] Instr_in, Instr_out;
    int total = 0;
    int bad = 0;
    int m_fwd [32];
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    esm_unmap dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .Instr_in(Instr_in),
        .RegWrite(RegWrite),
        .ALUSrc(ALUSrc),
        .out_valid(out_valid),
        .Instr_out(Instr_out)
    );

    function automatic int m_inv(int p);
        for (int i = 0; i < 32; i++) if (m_fwd[i] == p) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_map(logic [31:0] x, logic as, bit to_phys);
        logic [31:0] r;
        int pos [3];
        int v;
        pos = '{7, 15, 20};
        r = x;
        for (int f = 0; f < 3; f++) begin
            if (!(f == 2 && as)) begin
                v = int'(x[pos[f] +: 5]);
                v = to_phys ? m_fwd[v] : m_inv(v);
                r[pos[f] +: 5] = v[4:0];
            end
        end
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_fwd[i] = i;
        m_lfsr = 16'hACE1;
    endtask

    task automatic m_update(logic [31:0] logical, logic rw);
        int rd, kk, t;
        if (rw) begin
            rd = int'(logical[11:7]);
            kk = int'(m_lfsr[4:0]);
            if (kk != 0 && rd != 0 && kk != rd) begin
                t = m_fwd[rd];
                m_fwd[rd] = m_fwd[kk];
                m_fwd[kk] = t;
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        logic ok, match;
        ok = (dut.fwd[0] === 5'd0) && (dut.inv[0] === 5'd0);
        match = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (dut.inv[dut.fwd[i]] !== 5'(i)) ok = 1'b0;
            if (dut.fwd[i] !== 5'(m_fwd[i])) match = 1'b0;
        end
        chk("invariant", 32'(ok), 32'd1);
        chk("fwd_vs_model", 32'(match), 32'd1);
        chk("lfsr", 32'(dut.lfsr), 32'(m_lfsr));
    endtask

    task automatic cyc(logic r, logic iv, logic [31:0] ins, logic rw, logic as);
        rst = r;
        in_valid = iv;
        Instr_in = ins;
        RegWrite = rw;
        ALUSrc = as;
        @(posedge clk);
        #1;
    endtask

    task automatic send(string tag, logic [31:0] phys, logic rw, logic as);
        logic [31:0] exp;
        exp = m_map(phys, as, 0);
        m_update(exp, rw);
        cyc(1'b0, 1'b1, phys, rw, as);
        chk({tag, "_out"}, Instr_out, exp);
        chk({tag, "_ov"}, 32'(out_valid), 32'd1);
        chk_state();
    endtask

    initial begin
        logic [31:0] held, lg, ph;
        logic rw, as;
        m_reset();
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_out", Instr_out, 32'h0);
        chk("rst_lfsr", 32'(dut.lfsr), 32'h0000ACE1);
        chk_state();

        send("add_id", 32'h00C58533, 1'b1, 1'b0);
        chk("add_const", Instr_out, 32'h00C58533);
        send("addi_imm", 32'h00408613, 1'b1, 1'b1);
        chk("addi_const", Instr_out, 32'h00450613);
        send("rd0", 32'h00050013, 1'b1, 1'b1);

        held = Instr_out;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, $urandom, 1'b1, 1'($urandom));
            chk("idle_ov", 32'(out_valid), 32'd0);
            chk("idle_hold", Instr_out, held);
            chk_state();
        end

        send("mid", 32'h003100B3, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, $urandom, 1'b1, 1'b0);
        m_reset();
        chk("rst2_ov", 32'(out_valid), 32'd0);
        chk("rst2_out", Instr_out, 32'h0);
        chk("rst2_lfsr", 32'(dut.lfsr), 32'h0000ACE1);
        chk_state();
        send("post_rst", 32'h00C58533, 1'b1, 1'b0);
        chk("post_rst_const", Instr_out, 32'h00C58533);

        for (int n = 0; n < 1000; n++) begin
            lg = $urandom;
            rw = 1'($urandom_range(0, 3) != 0);
            as = 1'($urandom);
            ph = m_map(lg, as, 1);
            m_update(lg, rw);
            cyc(1'b0, 1'b1, ph, rw, as);
            chk("stream_out", Instr_out, lg);
            chk("stream_ov", 32'(out_valid), 32'd1);
            chk_state();
        end
        in_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/esm_unmap.md
# esm_unmap

- Receive-side counterpart of the ESM register-scrambling stage.
- Takes a 32-bit RISC-V instruction whose register fields hold physical (scrambled) indices and restores the logical indices.
- Keeps a forward map, an inverse map and an LFSR in lock-step with ESM, and reshuffles the mapping after every register-writing instruction.
- Sits between the scrambled instruction store and the core decode stage, with one cycle of latency.

## Interface
- `Instruction_word_size`, default 32: instruction width; only 32 is supported.
- `bs`, default 16: LFSR width.
- `SEED`, default 16'hACE1: LFSR reset value; must match ESM.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: `Instr_in` is valid this cycle.
- `Instr_in` input, 32 bits: scrambled instruction.
- `RegWrite` input, 1 bit: the instruction writes rd. Qualified by `in_valid`.
- `ALUSrc` input, 1 bit: bits [24:20] are immediate, not rs2. Qualified by `in_valid`.
- `out_valid` output, 1 bit: `Instr_out` is valid.
- `Instr_out` output, 32 bits: restored instruction.

## Operation
- Register fields:
  - rd = [11:7], rs1 = [19:15], rs2 = [24:20].
  - All other bits pass through unchanged.
- State:
  - `fwd[32]` holds logical→physical indices; `inv[32]` holds physical→logical indices. Both are 5 bits per entry.
  - `lfsr` is `bs` bits wide.
  - Reset state: both maps are identity, `lfsr = SEED`.
- Decode, on a valid instruction, using the current tables:
  - rd_l = inv[rd_p], rs1_l = inv[rs1_p].
  - rs2_l = inv[rs2_p] when ALUSrc=0; bits [24:20] are passed raw when ALUSrc=1.
  - Entry 0 always maps to 0.
- Update, applied only when in_valid=1 and RegWrite=1:
  - k = lfsr[4:0].
  - If k≠0, rd_l≠0 and k≠rd_l, swap logical rd_l with logical k:
    - fwd[rd_l]←fwd[k], fwd[k]←fwd[rd_l].
    - inv[fwd[rd_l]]←k, inv[fwd[k]]←rd_l (fwd values taken before the swap).
  - The LFSR advances once, whether or not a swap occurs.
  - LFSR step is Fibonacci: shift left, new bit[0] = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
- When in_valid=0 or RegWrite=0: no table change and no LFSR step.
- Invariant: after every update, inv[fwd[i]] = i for all i, and fwd[0] = inv[0] = 0.

## Timing
- Latency is 1 cycle: an instruction sampled at edge N appears on `Instr_out` with out_valid=1 after edge N.
- Throughput is one instruction per cycle with no stalls. Instruction N+1 in the next cycle decodes with the tables as updated by instruction N.
- `Instr_out` holds its last value while out_valid=0.
- Reset values: out_valid=0, Instr_out=0, identity maps, lfsr=SEED.
- rst dominates in_valid in the same cycle. The instruction in that cycle is dropped and no update is made.
- Reset mid-stream discards all mapping history; ESM must be reset in the same cycle.

## Structure
- Package `esm_pkg`: field bit positions, REG_IDX_W=5, NUM_REGS=32, LFSR tap constants, default SEED. Shared with ESM so both ends stay bit-identical.
- Sub-module `esm_lfsr`: ports clk, rst, step, seed, and the state output. Instanced identically in ESM.
- Top level holds the two map arrays, the decode muxes, the swap logic and the output register.

## Test plan
- Reset, then valid 32'h00C58533 with RegWrite=1, ALUSrc=0 → next cycle Instr_out=32'h00C58533, out_valid=1. Identity decode holds; k=1 and rd_l=10 swap logical 1↔10.
- Next cycle, valid 32'h00408613 with RegWrite=1, ALUSrc=1 → Instr_out=32'h00450613. Physical 1 decodes to logical x10, and imm bits [24:20]=4 are untouched.
- Valid instruction with rd=0 and RegWrite=1 (for example 32'h00050013) → fields restored, no swap, LFSR advanced once (check lfsr against the reference step).
- in_valid=0 for 3 cycles with random Instr_in → out_valid=0, Instr_out holds, tables and lfsr unchanged.
- rst=1 with in_valid=1 mid-stream → next cycle out_valid=0, Instr_out=0, lfsr=16'hACE1. The following 32'h00C58533 decodes through identity.
- 1000 random valid instructions through ESM→esm_unmap back-to-back → Instr_out equals the original stream. The invariant inv[fwd[i]]=i is asserted every cycle.
